// File: rtl/stopwatch_ctrl.sv
// Stopwatch mode controller and minutes/seconds time base with digit-blink mask.
// Optional clear button enabled by defining STOPWATCH_CLEAR_EN.
module stopwatch_ctrl #(
  parameter int unsigned ONE_HZ_DIV = 100_000_000,
  parameter int unsigned ADJ_DIV    = 50_000_000,
  parameter int unsigned BLINK_DIV  = 25_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pauseBtn,
  input  logic       adjSw,
  input  logic       selSw,
`ifdef STOPWATCH_CLEAR_EN
  input  logic       clearBtn,
`endif
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic       paused,
  output logic       adjusting,
  output logic [3:0] blankMask
);

  localparam int unsigned W1 = (ONE_HZ_DIV > 1) ? $clog2(ONE_HZ_DIV) : 1;
  localparam int unsigned WA = (ADJ_DIV > 1)    ? $clog2(ADJ_DIV)    : 1;
  localparam int unsigned WB = (BLINK_DIV > 1)  ? $clog2(BLINK_DIV)  : 1;
  localparam logic [W1-1:0] LAST1 = W1'(ONE_HZ_DIV - 1);
  localparam logic [WA-1:0] LASTA = WA'(ADJ_DIV - 1);
  localparam logic [WB-1:0] LASTB = WB'(BLINK_DIV - 1);

  typedef enum logic [1:0] {
    S_RUN,
    S_PAUSED,
    S_ADJUST
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_paused;
  logic            w_paused_nxt;
  logic            r_adjusting;
  logic            r_pause_prev;
  logic [5:0]      r_min;
  logic [5:0]      r_sec;
  logic [5:0]      w_min_nxt;
  logic [5:0]      w_sec_nxt;
  logic [W1-1:0]   r_div1;
  logic [WA-1:0]   r_divA;
  logic [WB-1:0]   r_divB;
  logic            r_blink;
  logic [3:0]      r_mask;
  logic [3:0]      w_mask_nxt;
  logic            w_pause_edge;
  logic            w_run_tick;
  logic            w_adj_tick;
  logic            w_blink_tick;
  logic            w_clear_edge;

  function automatic logic [5:0] inc59(input logic [5:0] v);
    return (v == 6'd59) ? 6'd0 : v + 6'd1;
  endfunction

  assign w_pause_edge = pauseBtn & ~r_pause_prev;
  assign w_run_tick   = (r_state == S_RUN)    && (r_div1 == LAST1);
  assign w_adj_tick   = (r_state == S_ADJUST) && (r_divA == LASTA);
  assign w_blink_tick = (r_divB == LASTB);

`ifdef STOPWATCH_CLEAR_EN
  logic r_clear_prev;
  assign w_clear_edge = clearBtn & ~r_clear_prev & (r_state == S_PAUSED);

  always_ff @(posedge clk) begin
    if (reset) r_clear_prev <= 1'b0;
    else       r_clear_prev <= clearBtn;
  end
`else
  assign w_clear_edge = 1'b0;
`endif

  // adjSw takes priority over pause edges in every state
  always_comb begin
    w_state_nxt  = r_state;
    w_paused_nxt = r_paused;
    case (r_state)
      S_RUN: begin
        if (adjSw) w_state_nxt = S_ADJUST;
        else if (w_pause_edge) begin
          w_state_nxt  = S_PAUSED;
          w_paused_nxt = 1'b1;
        end
      end
      S_PAUSED: begin
        if (adjSw) w_state_nxt = S_ADJUST;
        else if (w_pause_edge) begin
          w_state_nxt  = S_RUN;
          w_paused_nxt = 1'b0;
        end
      end
      S_ADJUST: begin
        if (!adjSw) w_state_nxt = r_paused ? S_PAUSED : S_RUN;
      end
      default: w_state_nxt = S_RUN;
    endcase
  end

  // A RUN tick is dropped when adjSw rises on the same edge
  always_comb begin
    w_min_nxt = r_min;
    w_sec_nxt = r_sec;
    if (w_run_tick && !adjSw) begin
      w_sec_nxt = inc59(r_sec);
      if (r_sec == 6'd59) w_min_nxt = inc59(r_min);
    end else if (w_adj_tick && adjSw) begin
      if (selSw) w_sec_nxt = inc59(r_sec);
      else       w_min_nxt = inc59(r_min);
    end else if (w_clear_edge) begin
      w_min_nxt = '0;
      w_sec_nxt = '0;
    end
  end

  always_comb begin
    w_mask_nxt = '0;
    case (r_state)
      S_PAUSED: if (r_blink) w_mask_nxt = '1;
      S_ADJUST: if (r_blink) w_mask_nxt = selSw ? 4'b0011 : 4'b1100;
      default:  w_mask_nxt = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_RUN;
      r_paused     <= 1'b0;
      r_adjusting  <= 1'b0;
      r_pause_prev <= 1'b0;
      r_min        <= '0;
      r_sec        <= '0;
      r_div1       <= '0;
      r_divA       <= '0;
      r_divB       <= '0;
      r_blink      <= 1'b0;
      r_mask       <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_paused     <= w_paused_nxt;
      r_adjusting  <= (w_state_nxt == S_ADJUST);
      r_pause_prev <= pauseBtn;
      r_min        <= w_min_nxt;
      r_sec        <= w_sec_nxt;
      r_mask       <= w_mask_nxt;
      // Dividers count only while the mode is held, so re-entry starts a full period
      if (r_state != S_RUN || w_state_nxt != S_RUN || w_run_tick || w_clear_edge)
        r_div1 <= '0;
      else
        r_div1 <= r_div1 + W1'(1);
      if (r_state != S_ADJUST || w_state_nxt != S_ADJUST || w_adj_tick)
        r_divA <= '0;
      else
        r_divA <= r_divA + WA'(1);
      if (w_blink_tick) begin
        r_divB  <= '0;
        r_blink <= ~r_blink;
      end else begin
        r_divB  <= r_divB + WB'(1);
      end
    end
  end

  assign minutes   = r_min;
  assign seconds   = r_sec;
  assign paused    = r_paused;
  assign adjusting = r_adjusting;
  assign blankMask = r_mask;

endmodule
